// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the (7,4) Hamming code.
// Bit k-1 of a codeword holds Hamming position k: {d4,d3,d2,p3,d1,p2,p1}.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  // Bit index of each Hamming position inside a codeword vector.
  localparam int P1_IDX = 0;  // position 1
  localparam int P2_IDX = 1;  // position 2
  localparam int D1_IDX = 2;  // position 3
  localparam int P3_IDX = 3;  // position 4
  localparam int D2_IDX = 4;  // position 5
  localparam int D3_IDX = 5;  // position 6
  localparam int D4_IDX = 6;  // position 7

  // Syndrome bit j is the parity over every position whose index has bit j set,
  // so a single flipped position k yields syndrome value k.
  function automatic logic [2:0] calc_syndrome(input logic [CODE_W-1:0] c);
    logic [2:0] s;
    s[0] = c[P1_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D4_IDX];
    s[1] = c[P2_IDX] ^ c[D1_IDX] ^ c[D3_IDX] ^ c[D4_IDX];
    s[2] = c[P3_IDX] ^ c[D2_IDX] ^ c[D3_IDX] ^ c[D4_IDX];
    return s;
  endfunction

  // Pull the data nibble {d4,d3,d2,d1} out of a codeword.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[D4_IDX], c[D3_IDX], c[D2_IDX], c[D1_IDX]};
  endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Upstream/downstream sockets of the Hamming decoder plus its status outputs.
// The slave modport is the decoder's view; the master modport is the peer's view.
interface hamming_decoder_if
  import hamming_pkg::*;
#(
  parameter int CNT_WIDTH = 16
);

  logic [CODE_W-1:0]    i_code;
  logic                 i_valid;
  logic                 o_ready;
  logic [DATA_W-1:0]    o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_corr;
  logic [2:0]           o_syn;
  logic                 o_last;
  logic [CNT_WIDTH-1:0] o_word_cnt;
  logic [CNT_WIDTH-1:0] o_corr_cnt;

  modport slave (
    input  i_code, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_corr, o_syn, o_last, o_word_cnt, o_corr_cnt
  );

  modport master (
    output i_code, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_corr, o_syn, o_last, o_word_cnt, o_corr_cnt
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome computation and single-bit correction.
// A nonzero syndrome names the position to flip; zero leaves the word untouched.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [2:0]        syn,
  output logic [CODE_W-1:0] corrected
);

  // Compute the syndrome and flip the bit it points at.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    syn       = calc_syndrome(code);
    corrected = code;
    for (int k = 0; k < CODE_W; k++) begin
      if (syn == 3'(k + 1)) begin
        corrected[k] = ~code[k];
      end
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage (7,4) Hamming decoder with valid/ready sockets on both sides.
// S1 holds the accepted codeword, S2 holds the corrected nibble and flags.
// Word/correction counters saturate; a frame index marks the last word of each block.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int BLOCK_LEN = 64,
  parameter int CNT_WIDTH = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  hamming_decoder_if.slave bus
);

  localparam int               IDX_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  logic                 s1_valid;
  logic [CODE_W-1:0]    s1_code;
  logic                 s2_valid;
  logic [DATA_W-1:0]    s2_data;
  logic [2:0]           s2_syn;
  logic                 s2_corr;
  logic [IDX_W-1:0]     frame_idx;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [CNT_WIDTH-1:0] corr_cnt;

  logic [2:0]           syn;
  logic [CODE_W-1:0]    corrected;
  logic                 ready;
  logic                 accept;
  logic                 advance;
  logic                 out_xfer;

  hamming_syndrome u_syndrome (
    .code      (s1_code),
    .syn       (syn),
    .corrected (corrected)
  );

  // Handshake decode: ready depends only on stage occupancy and i_ready, never on i_valid.
  always_comb begin
    out_xfer = s2_valid && bus.i_ready;
    advance  = s1_valid && (!s2_valid || bus.i_ready);
    ready    = !i_rst && (!s1_valid || !s2_valid || bus.i_ready);
    accept   = bus.i_valid && ready;
  end

  // Pipeline registers: S1 captures the codeword, S2 captures the decoded result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: payload registers are cleared as well, so o_data/o_syn read 0 right after reset.
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_syn   <= '0;
      s2_corr  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let S1 and S2 both sample pre-edge values, so the pipe shifts cleanly.
      if (accept) begin
        s1_valid <= 1'b1;
        s1_code  <= bus.i_code;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        s2_valid <= 1'b1;
        s2_data  <= extract_data(corrected);
        s2_syn   <= syn;
        s2_corr  <= (syn != 3'd0);
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Statistics and frame position, advanced only when the downstream takes a word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_cnt  <= '0;
      corr_cnt  <= '0;
      frame_idx <= '0;
    end else if (out_xfer) begin
      if (word_cnt != '1) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
      if (s2_corr && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_WIDTH'(1);
      end
      if (frame_idx == LAST_IDX) begin
        frame_idx <= '0;
      end else begin
        frame_idx <= frame_idx + IDX_W'(1);
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = s2_valid;
  assign bus.o_data     = s2_data;
  assign bus.o_syn      = s2_syn;
  assign bus.o_corr     = s2_corr;
  assign bus.o_last     = s2_valid && (frame_idx == LAST_IDX);
  assign bus.o_word_cnt = word_cnt;
  assign bus.o_corr_cnt = corr_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder. Two instances share stimulus:
// dut_a uses default parameters, dut_b uses BLOCK_LEN=4 / CNT_WIDTH=3.
module tb_hamming_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] code;
  logic       valid;
  logic       rdy;

  int n_cmp;
  int n_bad;

  hamming_decoder_if #(.CNT_WIDTH(16)) ifa ();
  hamming_decoder_if #(.CNT_WIDTH(3))  ifb ();

  assign ifa.i_code  = code;
  assign ifa.i_valid = valid;
  assign ifa.i_ready = rdy;
  assign ifb.i_code  = code;
  assign ifb.i_valid = valid;
  assign ifb.i_ready = rdy;

  hamming_decoder #(.BLOCK_LEN(64), .CNT_WIDTH(16)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  hamming_decoder #(.BLOCK_LEN(4),  .CNT_WIDTH(3))  dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Stream state shared between the driver and the test tasks.
  logic [6:0] stim[$];
  logic [3:0] got_data[$];
  logic [2:0] got_syn[$];
  logic       got_corr[$];
  logic       got_last_b[$];
  int         first_out;
  int         last_out;
  int         ready_low;
  int         hold_err;

  // Independent encoder: parity equations written from the data bits.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic logic [6:0] flip(input logic [6:0] c, input int pos);
    logic [6:0] m;
    m = 7'd1;
    if (pos == 0) return c;
    return c ^ (m << (pos - 1));
  endfunction

  task automatic apply_reset();
    rst = 1'b1; valid = 1'b0; rdy = 1'b1; code = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives stim[0..n-1]; i_ready is low for stall_len cycles from cycle stall_from.
  // Collects transferred outputs and stall-hold observations. Starts and ends at posedge+1.
  task automatic run_stream(input int n, input int stall_from, input int stall_len);
    int         sent;
    int         cyc;
    logic       p_stall;
    logic [3:0] p_data;
    logic [2:0] p_syn;
    logic       p_corr;
    logic       p_last;
    got_data.delete(); got_syn.delete(); got_corr.delete(); got_last_b.delete();
    sent = 0; cyc = 0; first_out = -1; last_out = -1; ready_low = 0; hold_err = 0;
    p_stall = 1'b0; p_data = '0; p_syn = '0; p_corr = 1'b0; p_last = 1'b0;
    while (got_data.size() < n && cyc < n + stall_len + 20) begin
      valid = (sent < n);
      if (sent < n) code = stim[sent];
      else code = '0;
      rdy = !(cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      if (p_stall && (ifa.o_valid !== 1'b1 || ifa.o_data !== p_data || ifa.o_syn !== p_syn ||
                      ifa.o_corr !== p_corr || ifa.o_last !== p_last)) hold_err++;
      if (!rdy && ifa.o_ready === 1'b0) ready_low++;
      if (ifa.o_valid === 1'b1 && first_out < 0) first_out = cyc;
      if (valid && ifa.o_ready === 1'b1) sent++;
      if (ifa.o_valid === 1'b1 && rdy) begin
        got_data.push_back(ifa.o_data);
        got_syn.push_back(ifa.o_syn);
        got_corr.push_back(ifa.o_corr);
        got_last_b.push_back(ifb.o_last);
        last_out = cyc;
      end
      p_stall = (ifa.o_valid === 1'b1) && !rdy;
      p_data = ifa.o_data; p_syn = ifa.o_syn; p_corr = ifa.o_corr; p_last = ifa.o_last;
      @(posedge clk); #1;
      cyc++;
    end
    valid = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; rdy = 1'b1; code = '0;
    @(negedge clk);
    n_cmp++; if (ifa.o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cycle_ready: got %b want 0", ifa.o_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifa.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifa.o_valid); end
    n_cmp++; if (ifa.o_data !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", ifa.o_data); end
    n_cmp++; if (ifa.o_syn !== 3'd0) begin n_bad++; $display("FAIL reset_syn: got %0d want 0", ifa.o_syn); end
    n_cmp++; if (ifa.o_corr !== 1'b0) begin n_bad++; $display("FAIL reset_corr: got %b want 0", ifa.o_corr); end
    n_cmp++; if (ifa.o_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", ifa.o_last); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_word_cnt: got %0d want 0", ifa.o_word_cnt); end
    n_cmp++; if (ifa.o_corr_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_corr_cnt: got %0d want 0", ifa.o_corr_cnt); end
    n_cmp++; if (ifa.o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", ifa.o_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_clean_word();
    stim.delete(); stim.push_back(7'h55);
    run_stream(1, 0, 0);
    n_cmp++; if (got_data.size() != 1) begin n_bad++; $display("FAIL clean_count: got %0d want 1", got_data.size()); end
    else begin
      n_cmp++; if (got_data[0] !== 4'b1011) begin n_bad++; $display("FAIL clean_data: got %b want 1011", got_data[0]); end
      n_cmp++; if (got_syn[0] !== 3'd0) begin n_bad++; $display("FAIL clean_syn: got %0d want 0", got_syn[0]); end
      n_cmp++; if (got_corr[0] !== 1'b0) begin n_bad++; $display("FAIL clean_corr: got %b want 0", got_corr[0]); end
    end
    n_cmp++; if (first_out != 2) begin n_bad++; $display("FAIL clean_latency: got %0d want 2", first_out); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd1) begin n_bad++; $display("FAIL clean_word_cnt: got %0d want 1", ifa.o_word_cnt); end
    n_cmp++; if (ifa.o_corr_cnt !== 16'd0) begin n_bad++; $display("FAIL clean_corr_cnt: got %0d want 0", ifa.o_corr_cnt); end
  endtask

  task automatic test_single_error();
    stim.delete(); stim.push_back(7'h45);
    run_stream(1, 0, 0);
    n_cmp++; if (got_data.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got_data.size()); end
    else begin
      n_cmp++; if (got_data[0] !== 4'b1011) begin n_bad++; $display("FAIL single_data: got %b want 1011", got_data[0]); end
      n_cmp++; if (got_syn[0] !== 3'd5) begin n_bad++; $display("FAIL single_syn: got %0d want 5", got_syn[0]); end
      n_cmp++; if (got_corr[0] !== 1'b1) begin n_bad++; $display("FAIL single_corr: got %b want 1", got_corr[0]); end
    end
    n_cmp++; if (ifa.o_corr_cnt !== 16'd1) begin n_bad++; $display("FAIL single_corr_cnt: got %0d want 1", ifa.o_corr_cnt); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd2) begin n_bad++; $display("FAIL single_word_cnt: got %0d want 2", ifa.o_word_cnt); end
    @(negedge clk);
    n_cmp++; if (ifa.o_valid !== 1'b0) begin n_bad++; $display("FAIL idle_drain_valid: got %b want 0", ifa.o_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    apply_reset();
    stim.delete();
    for (int n = 0; n < 16; n++)
      for (int f = 0; f < 8; f++) stim.push_back(flip(enc(4'(n)), f));
    run_stream(128, 0, 0);
    n_cmp++; if (got_data.size() != 128) begin n_bad++; $display("FAIL sweep_count: got %0d want 128", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== 4'(i / 8)) begin n_bad++; $display("FAIL sweep_data[%0d]: got %h want %h", i, got_data[i], 4'(i / 8)); end
      n_cmp++; if (got_syn[i] !== 3'(i % 8)) begin n_bad++; $display("FAIL sweep_syn[%0d]: got %0d want %0d", i, got_syn[i], i % 8); end
      n_cmp++; if (got_corr[i] !== ((i % 8) != 0)) begin n_bad++; $display("FAIL sweep_corr[%0d]: got %b want %b", i, got_corr[i], (i % 8) != 0); end
    end
    n_cmp++; if (last_out != 129) begin n_bad++; $display("FAIL sweep_throughput: last out cycle %0d want 129", last_out); end
    n_cmp++; if (ifa.o_corr_cnt !== 16'd112) begin n_bad++; $display("FAIL sweep_corr_cnt: got %0d want 112", ifa.o_corr_cnt); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd128) begin n_bad++; $display("FAIL sweep_word_cnt: got %0d want 128", ifa.o_word_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(flip(enc(4'(i + 3)), i % 8));
    run_stream(10, 4, 5);
    n_cmp++; if (got_data.size() != 10) begin n_bad++; $display("FAIL bp_count: got %0d want 10", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== 4'(i + 3)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], 4'(i + 3)); end
    end
    n_cmp++; if (ready_low != 5) begin n_bad++; $display("FAIL bp_ready_low: got %0d cycles want 5", ready_low); end
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable stall cycles want 0", hold_err); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd10) begin n_bad++; $display("FAIL bp_word_cnt: got %0d want 10", ifa.o_word_cnt); end
  endtask

  task automatic test_frame_sat();
    apply_reset();
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(enc(4'(i)));
    run_stream(10, 0, 0);
    n_cmp++; if (got_last_b.size() != 10) begin n_bad++; $display("FAIL frame_count: got %0d want 10", got_last_b.size()); end
    for (int i = 0; i < got_last_b.size(); i++) begin
      n_cmp++; if (got_last_b[i] !== (i == 3 || i == 7)) begin n_bad++; $display("FAIL frame_last[%0d]: got %b want %b", i, got_last_b[i], (i == 3 || i == 7)); end
    end
    n_cmp++; if (ifb.o_word_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_word_cnt: got %0d want 7", ifb.o_word_cnt); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd10) begin n_bad++; $display("FAIL frame_wide_cnt: got %0d want 10", ifa.o_word_cnt); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    stim.delete(); stim.push_back(enc(4'h1)); stim.push_back(enc(4'h2));
    run_stream(2, 0, 0);
    valid = 1'b1; rdy = 1'b0; code = enc(4'hE);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (ifa.o_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full_valid: got %b want 1", ifa.o_valid); end
    n_cmp++; if (ifa.o_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full_ready: got %b want 0", ifa.o_ready); end
    @(posedge clk); #1;
    rst = 1'b1; rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifa.o_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", ifa.o_ready); end
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifa.o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", ifa.o_valid); end
    n_cmp++; if (ifa.o_word_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_word_cnt: got %0d want 0", ifa.o_word_cnt); end
    n_cmp++; if (ifa.o_corr_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_corr_cnt: got %0d want 0", ifa.o_corr_cnt); end
    n_cmp++; if (ifb.o_word_cnt !== 3'd0) begin n_bad++; $display("FAIL mid_word_cnt_b: got %0d want 0", ifb.o_word_cnt); end
    n_cmp++; if (ifa.o_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", ifa.o_ready); end
    @(posedge clk); #1;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(enc(4'(i + 8)));
    run_stream(4, 0, 0);
    n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("FAIL mid_after_count: got %0d want 4", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_cmp++; if (got_data[i] !== 4'(i + 8)) begin n_bad++; $display("FAIL mid_after_data[%0d]: got %h want %h", i, got_data[i], 4'(i + 8)); end
      n_cmp++; if (got_last_b[i] !== (i == 3)) begin n_bad++; $display("FAIL mid_after_last[%0d]: got %b want %b", i, got_last_b[i], i == 3); end
    end
    n_cmp++; if (ifa.o_word_cnt !== 16'd4) begin n_bad++; $display("FAIL mid_after_word_cnt: got %0d want 4", ifa.o_word_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; valid = 1'b0; rdy = 1'b1; code = '0;
    test_reset();
    test_clean_word();
    test_single_error();
    test_sweep();
    test_back_to_back();
    test_frame_sat();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
